// File: rtl/sr_ff_driver.sv
// Drives a bank of external SR flip-flops to a target word, verifies the
// readback and re-drives up to MAX_RETRY extra times before giving up.
module sr_ff_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DRIVE, CHECK} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_tgt, w_tgt_nxt;
  logic [WIDTH-1:0] r_s, w_s_nxt;
  logic [WIDTH-1:0] r_r, w_r_nxt;
  logic [RW-1:0]    r_retry, w_retry_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_ready;
  logic             r_busy;
  logic             w_hs;

  assign w_hs = tgt_valid & (r_state == IDLE);

  // Next-state and next-output decode; excitation is only ever produced in CALC.
  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_retry_nxt = r_retry;
    w_s_nxt     = '0;
    w_r_nxt     = '0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_tgt_nxt   = tgt_data;
          w_retry_nxt = '0;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        // Set only bits that must rise, reset only bits that must fall: never 11.
        w_s_nxt     = r_tgt & ~q_in;
        w_r_nxt     = ~r_tgt & q_in;
        w_state_nxt = DRIVE;
      end
      DRIVE: begin
        w_state_nxt = CHECK;
      end
      CHECK: begin
        if (q_in == r_tgt) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_retry < RW'(MAX_RETRY)) begin
          w_retry_nxt = r_retry + RW'(1);
          w_state_nxt = CALC;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; ready/busy track the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tgt   <= '0;
      r_retry <= '0;
      r_s     <= '0;
      r_r     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_retry <= w_retry_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign tgt_ready = r_ready;
  assign busy      = r_busy;
  assign s_out     = r_s;
  assign r_out     = r_r;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_sr_ff_driver.sv
// Bench for sr_ff_driver: SR-flop plant with stuck-bit injection, directed
// cases plus random writes checked against a transaction-level timing model.
module tb_sr_ff_driver;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_RETRY = 3;

  logic             clk;
  logic             rst;
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] q_in;
  logic             busy;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_errs   = 0;

  logic [WIDTH-1:0] plant_q;
  logic [WIDTH-1:0] st0;
  logic [WIDTH-1:0] st1;
  logic [WIDTH-1:0] load_val;
  logic             load;
  logic             mon_en;

  sr_ff_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .s_out     (s_out),
    .r_out     (r_out),
    .q_in      (q_in),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External SR flops: set wins only where reset is low; stuck masks override.
  always @(posedge clk) begin
    if (load) plant_q <= (load_val & ~st0) | st1;
    else      plant_q <= (((plant_q | s_out) & ~r_out) & ~st0) | st1;
  end
  assign q_in = plant_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) check("sr_excl", 32'(s_out & r_out), 32'd0);
  end

  task automatic preload(input logic [WIDTH-1:0] v);
    load     = 1'b1;
    load_val = v;
    @(posedge clk); #1;
    load     = 1'b0;
  endtask

  task automatic check_cycle(input string tag, input logic [WIDTH-1:0] es, input logic [WIDTH-1:0] er,
                             input logic eb, input logic erdy, input logic ed, input logic ee);
    check({tag, ".s"},     32'(s_out),     32'(es));
    check({tag, ".r"},     32'(r_out),     32'(er));
    check({tag, ".busy"},  32'(busy),      32'(eb));
    check({tag, ".ready"}, 32'(tgt_ready), 32'(erdy));
    check({tag, ".done"},  32'(done),      32'(ed));
    check({tag, ".err"},   32'(err),       32'(ee));
  endtask

  // Called at posedge+1 of the handshake cycle t with the DUT idle.
  // Model: attempt a drives at t+2+3a; a write needs one attempt if the target
  // is reachable despite stuck bits, otherwise MAX_RETRY+1; finish at t+1+3n.
  task automatic do_write(input logic [WIDTH-1:0] tgt, input bit hold);
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q_after;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] es;
    logic [WIDTH-1:0] er;
    bit               ok;
    int               n;
    int               last;
    q0      = plant_q;
    q_after = (tgt & ~st0) | st1;
    ok      = (q_after == tgt);
    n       = ok ? 1 : int'(MAX_RETRY) + 1;
    last    = 1 + 3 * n;
    tgt_valid = 1'b1;
    tgt_data  = tgt;
    check("hs.ready", 32'(tgt_ready), 32'd1);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == last) begin
        check_cycle("end", '0, '0, 1'b0, 1'b1, ok, !ok);
        if (!hold) tgt_valid = 1'b0;
      end else begin
        es = '0;
        er = '0;
        if (k >= 2 && ((k - 2) % 3) == 0) begin
          qa = ((k - 2) / 3 == 0) ? q0 : q_after;
          es = tgt & ~qa;
          er = ~tgt & qa;
        end
        check_cycle("run", es, er, 1'b1, 1'b0, 1'b0, 1'b0);
        if (!hold) begin
          tgt_valid = 1'($urandom);
          tgt_data  = WIDTH'($urandom);
        end
      end
    end
  endtask

  initial begin
    mon_en    = 1'b0;
    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    load      = 1'b1;
    load_val  = '0;
    st0       = '0;
    st1       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst    = 1'b0;
    load   = 1'b0;
    mon_en = 1'b1;

    preload(8'h0F);
    do_write(8'hF0, 1'b0);
    check("normal.q", 32'(plant_q), 32'hF0);

    preload(8'hA5);
    do_write(8'hA5, 1'b0);

    st0 = 8'h01;
    preload(8'h00);
    do_write(8'h01, 1'b0);
    st0 = '0;

    // Abort during DRIVE: excitation and busy drop right after the reset edge.
    preload(8'h00);
    tgt_valid = 1'b1;
    tgt_data  = 8'h5A;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    check("abort.drive_s", 32'(s_out), 32'h5A);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cycle("abort", '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_cycle("post_abort", '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    preload(8'h00);
    do_write(8'h3C, 1'b1);
    do_write(8'hC3, 1'b0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        st0 = WIDTH'($urandom) & WIDTH'($urandom);
        st1 = WIDTH'($urandom) & WIDTH'($urandom) & ~st0;
      end else begin
        st0 = '0;
        st1 = '0;
      end
      preload(WIDTH'($urandom));
      do_write(WIDTH'($urandom), 1'b0);
    end

    st0 = '0;
    st1 = '0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
